uart_rx_cmd_ctrl: RTL and testbench
===================================

Name: uart_rx_cmd_ctrl

Overview:
Sequencer between the UART_Rx datapath and the register bank. It turns the receiver's byte stream (P_DATA/data_valid/Parity_Error/Stop_Error) into framed register write/read requests. It checks sync, command, checksum and inter-byte timeout, and counts errors. It owns the receiver's PAR_EN/PAR_TYP/Prescale configuration and changes it only when the serial line is provably idle.

Parameters:
ADDR_WIDTH, 8, register address width (one byte on the wire)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 4096, max CLK cycles between bytes inside a frame
ERR_CNT_WIDTH, 8, saturating error counter width

Ports:
CLK  in  1  system clock (same clock as UART_Rx)
RST  in  1  synchronous active-low reset
RX_IN  in  1  raw serial line, used for idle detection only
rx_p_data  in  8  byte from UART_Rx P_DATA
rx_data_valid  in  1  one-cycle pulse, rx_p_data valid
rx_par_err  in  1  pulse from UART_Rx Parity_Error
rx_stp_err  in  1  pulse from UART_Rx Stop_Error
cfg_load  in  1  pulse, capture cfg_* as pending config
cfg_par_en  in  1  requested PAR_EN
cfg_par_typ  in  1  requested PAR_TYP
cfg_prescale  in  6  requested Prescale (legal: 4, 8, 16, 32)
rx_par_en  out  1  drives UART_Rx PAR_EN
rx_par_typ  out  1  drives UART_Rx PAR_TYP
rx_prescale  out  6  drives UART_Rx Prescale
cfg_rej  out  1  pulse, illegal cfg_prescale rejected
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_addr  out  ADDR_WIDTH  request address
reg_wdata  out  8  write data
frame_err  out  1  one-cycle pulse, frame aborted
err_code  out  2  valid with frame_err: 00 timeout, 01 line error, 10 bad cmd, 11 checksum
err_cnt  out  ERR_CNT_WIDTH  saturating error count
err_cnt_clr  in  1  clears err_cnt

Behaviour:
- Reset (RST=0 at posedge) values:
  - state IDLE; all strobes 0; reg_addr, reg_wdata, err_code, err_cnt 0.
  - rx_par_en 0, rx_par_typ 0, rx_prescale 8; no pending config; idle counter 0.
- Frame format:
  - Write: SYNC, CMD=8'h01, ADDR, DATA, CHK.
  - Read: SYNC, CMD=8'h02, ADDR, CHK.
  - CHK = XOR of all bytes after SYNC, excluding CHK.
- FSM states: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, ISSUE. Advances only on accepted bytes (rx_data_valid=1 with no error pulse that cycle).
  - IDLE: byte==SYNC_BYTE -> GET_CMD; any other byte is ignored silently.
  - GET_CMD: 01 or 02 -> GET_ADDR, running checksum = byte; any other value -> abort, code 10.
  - GET_ADDR: latch reg_addr, XOR into checksum. Write -> GET_DATA; read -> GET_CHK.
  - GET_DATA: latch reg_wdata, XOR into checksum -> GET_CHK.
  - GET_CHK: match -> ISSUE; mismatch -> abort, code 11.
  - ISSUE: exactly one cycle. reg_wr_en or reg_rd_en = 1 with reg_addr/reg_wdata stable, then -> IDLE. The strobe therefore appears 1 cycle after the CHK byte's data_valid.
  - A byte arriving during ISSUE is processed with IDLE rules.
- Line errors: rx_par_err or rx_stp_err pulse.
  - Outside IDLE/ISSUE: abort, code 01.
  - In IDLE/ISSUE: no frame_err, but err_cnt increments.
  - An error pulse wins over rx_data_valid in the same cycle; that byte is discarded.
- Timeout: counter resets on every accepted byte and in IDLE. In GET_* states, reaching TIMEOUT_CYCLES without a byte -> abort, code 00.
- Abort: frame_err=1 for one cycle with err_code; -> IDLE; no strobe issued; reg_addr/reg_wdata keep their last values.
- err_cnt: +1 per frame_err and per IDLE/ISSUE line error; saturates at all-ones. err_cnt_clr has priority over an increment in the same cycle.
- Config:
  - cfg_load with cfg_prescale not in {4,8,16,32}: cfg_rej pulse next cycle; pending config unchanged.
  - Legal cfg_load: overwrites pending config; last load wins.
  - Idle counter: counts consecutive cycles with RX_IN=1; cleared when RX_IN=0.
  - Pending config is applied to rx_* when state==IDLE and idle count >= 12*rx_prescale (current value). Clear the pending flag on apply.
  - rx_* never change in any other condition.
- Reset mid-frame: discards partial frame and pending config; outputs return to reset values.

Test Plan:
- Write frame A5,01,10,3C,2D at Prescale 8, no parity -> one reg_wr_en, reg_addr=10, reg_wdata=3C; frame_err never; err_cnt=0.
- Read frame A5,02,20,22 -> one reg_rd_en 1 cycle after last data_valid, reg_addr=20; reg_wr_en stays 0.
- Write A5,01,10,3C,2E -> frame_err with err_code=11, no strobe, err_cnt=1. Then A5,07 -> err_code=10, err_cnt=2.
- Even parity enabled, wrong parity bit on the ADDR byte -> frame_err code 01. A following good frame A5,02,20,22 -> reg_rd_en.
- A5,01 then line held high for 4096 cycles -> frame_err code 00. Force 255 errors -> err_cnt holds FF; err_cnt_clr -> 0.
- cfg_load (en=1, typ=1, prescale=16) mid-frame -> rx_* unchanged until frame end plus 96 idle cycles, then update. cfg_prescale=12 -> cfg_rej, rx_prescale unchanged.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames UART_Rx bytes into one-cycle register write/read strobes, counts errors, owns Rx line config.
// Strobes and frame_err are registered one cycle after the deciding byte; no backpressure, bytes arrive at line rate.
module uart_rx_cmd_ctrl #(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         ERR_CNT_WIDTH  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RX_IN,
    input  logic [7:0]               rx_p_data,
    input  logic                     rx_data_valid,
    input  logic                     rx_par_err,
    input  logic                     rx_stp_err,
    input  logic                     cfg_load,
    input  logic                     cfg_par_en,
    input  logic                     cfg_par_typ,
    input  logic [5:0]               cfg_prescale,
    output logic                     rx_par_en,
    output logic                     rx_par_typ,
    output logic [5:0]               rx_prescale,
    output logic                     cfg_rej,
    output logic                     reg_wr_en,
    output logic                     reg_rd_en,
    output logic [ADDR_WIDTH-1:0]    reg_addr,
    output logic [7:0]               reg_wdata,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    input  logic                     err_cnt_clr
);
    localparam int         TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int         IDLE_W    = 10;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [1:0] E_TIMEOUT = 2'b00;
    localparam logic [1:0] E_LINE    = 2'b01;
    localparam logic [1:0] E_CMD     = 2'b10;
    localparam logic [1:0] E_CHK     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_ISSUE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              line_err;
    logic              acc;
    logic              in_frame;
    logic              timed_out;
    logic              abort;
    logic [1:0]        abort_code;
    logic              cnt_inc;
    logic              is_wr;
    logic [7:0]        chk;
    logic [TO_W-1:0]   to_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_thr;
    logic              pend_vld;
    logic              pend_par_en;
    logic              pend_par_typ;
    logic [5:0]        pend_prescale;
    logic              cfg_legal;
    logic              cfg_apply;

    // An error pulse discards the byte that came with it.
    assign line_err  = rx_par_err | rx_stp_err;
    assign acc       = rx_data_valid & ~line_err;
    assign in_frame  = (state != S_IDLE) && (state != S_ISSUE);
    assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        abort_code = E_TIMEOUT;
        case (state)
            S_IDLE, S_ISSUE: begin
                state_nxt = S_IDLE;
                if (acc && (rx_p_data == SYNC_BYTE)) begin
                    state_nxt = S_CMD;
                end
            end
            default: begin
                if (line_err) begin
                    abort      = 1'b1;
                    abort_code = E_LINE;
                end else if (acc) begin
                    case (state)
                        S_CMD: begin
                            if ((rx_p_data == CMD_WR) || (rx_p_data == CMD_RD)) begin
                                state_nxt = S_ADDR;
                            end else begin
                                abort      = 1'b1;
                                abort_code = E_CMD;
                            end
                        end
                        S_ADDR:  state_nxt = is_wr ? S_DATA : S_CHK;
                        S_DATA:  state_nxt = S_CHK;
                        S_CHK: begin
                            if (rx_p_data == chk) begin
                                state_nxt = S_ISSUE;
                            end else begin
                                abort      = 1'b1;
                                abort_code = E_CHK;
                            end
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end else if (timed_out) begin
                    abort      = 1'b1;
                    abort_code = E_TIMEOUT;
                end
                if (abort) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        if (state == S_ISSUE) begin
            reg_wr_en = is_wr;
            reg_rd_en = ~is_wr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            is_wr     <= 1'b0;
            chk       <= 8'h00;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            to_cnt    <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_err <= abort;
            if (abort) begin
                err_code <= abort_code;
            end
            if (in_frame && !acc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            if (acc) begin
                case (state)
                    S_CMD: begin
                        is_wr <= (rx_p_data == CMD_WR);
                        chk   <= rx_p_data;
                    end
                    S_ADDR: begin
                        reg_addr <= ADDR_WIDTH'(rx_p_data);
                        chk      <= chk ^ rx_p_data;
                    end
                    S_DATA: begin
                        reg_wdata <= rx_p_data;
                        chk       <= chk ^ rx_p_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Line errors between frames are counted even though no frame is aborted.
    assign cnt_inc = abort | (line_err & ~in_frame);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (cnt_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    assign cfg_legal = (cfg_prescale == 6'd4) || (cfg_prescale == 6'd8) ||
                       (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
    // Twelve bit-times of continuous mark guarantees no character is in flight.
    assign idle_thr  = IDLE_W'(rx_prescale) * IDLE_W'(12);
    assign cfg_apply = pend_vld && (state == S_IDLE) && (idle_cnt >= idle_thr);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_par_en     <= 1'b0;
            rx_par_typ    <= 1'b0;
            rx_prescale   <= 6'd8;
            pend_vld      <= 1'b0;
            pend_par_en   <= 1'b0;
            pend_par_typ  <= 1'b0;
            pend_prescale <= 6'd8;
            idle_cnt      <= '0;
            cfg_rej       <= 1'b0;
        end else begin
            cfg_rej <= cfg_load & ~cfg_legal;
            if (!RX_IN) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (cfg_apply) begin
                rx_par_en   <= pend_par_en;
                rx_par_typ  <= pend_par_typ;
                rx_prescale <= pend_prescale;
                pend_vld    <= 1'b0;
            end
            if (cfg_load && cfg_legal) begin
                pend_par_en   <= cfg_par_en;
                pend_par_typ  <= cfg_par_typ;
                pend_prescale <= cfg_prescale;
                pend_vld      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: frame-level model checked every cycle, plus directed literal checks.
module tb_uart_rx_cmd_ctrl;
    localparam int T = 4096;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [7:0] rx_p_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic       rx_par_err = 1'b0;
    logic       rx_stp_err = 1'b0;
    logic       cfg_load = 1'b0;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic [5:0] cfg_prescale = 6'd8;
    logic       err_cnt_clr = 1'b0;
    logic       rx_par_en, rx_par_typ, cfg_rej, reg_wr_en, reg_rd_en, frame_err;
    logic [5:0] rx_prescale;
    logic [7:0] reg_addr, reg_wdata, err_cnt;
    logic [1:0] err_code;

    uart_rx_cmd_ctrl #(
        .ADDR_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .ERR_CNT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
        .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
        .cfg_load(cfg_load), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
        .cfg_prescale(cfg_prescale),
        .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ), .rx_prescale(rx_prescale),
        .cfg_rej(cfg_rej), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt),
        .err_cnt_clr(err_cnt_clr)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: owned solely by the compare process below.
    bit         armed = 1'b0;
    bit         m_in_frame;
    logic [7:0] m_buf[$];
    int         m_silent, m_cnt, m_hr;
    logic [7:0] m_addr, m_wdata;
    bit         m_pend;
    logic       m_pen, m_ptyp;
    logic [5:0] m_ppre;
    bit         e_wr, e_rd, e_ferr, e_rej;
    logic [1:0] e_code;
    logic       e_par_en, e_par_typ;
    logic [5:0] e_pre;
    int         wr_seen = 0, rd_seen = 0, ferr_seen = 0, rej_seen = 0;
    logic [1:0] last_code = 2'b00;

    always @(negedge CLK) begin
        bit         n_wr, n_rd, n_ferr, lerr, acc, inc, idle_ok;
        logic [1:0] n_code;
        logic [7:0] x;
        int         need;
        if (armed) begin
            check("wr_en", reg_wr_en, e_wr);
            check("rd_en", reg_rd_en, e_rd);
            check("frame_err", frame_err, e_ferr);
            if (e_ferr) check("err_code", err_code, e_code);
            check("reg_addr", reg_addr, m_addr);
            check("reg_wdata", reg_wdata, m_wdata);
            check("err_cnt", err_cnt, m_cnt);
            check("cfg_rej", cfg_rej, e_rej);
            check("rx_par_en", rx_par_en, e_par_en);
            check("rx_par_typ", rx_par_typ, e_par_typ);
            check("rx_prescale", rx_prescale, e_pre);
            if (reg_wr_en) wr_seen++;
            if (reg_rd_en) rd_seen++;
            if (cfg_rej) rej_seen++;
            if (frame_err) begin
                ferr_seen++;
                last_code = err_code;
            end
        end
        // Advance the model with the inputs the next rising edge will sample.
        if (!RST) begin
            armed = 1'b1;
            m_in_frame = 1'b0; m_buf.delete(); m_silent = 0; m_cnt = 0; m_hr = 0;
            m_addr = 8'h00; m_wdata = 8'h00; m_pend = 1'b0;
            e_wr = 1'b0; e_rd = 1'b0; e_ferr = 1'b0; e_rej = 1'b0; e_code = 2'b00;
            e_par_en = 1'b0; e_par_typ = 1'b0; e_pre = 6'd8;
        end else if (armed) begin
            n_wr = 1'b0; n_rd = 1'b0; n_ferr = 1'b0; n_code = 2'b00; inc = 1'b0;
            lerr = rx_par_err | rx_stp_err;
            acc = rx_data_valid && !lerr;
            idle_ok = !m_in_frame && !e_wr && !e_rd;
            if (m_pend && idle_ok && (m_hr >= 12 * int'(e_pre))) begin
                e_par_en = m_pen; e_par_typ = m_ptyp; e_pre = m_ppre; m_pend = 1'b0;
            end
            m_hr = RX_IN ? m_hr + 1 : 0;
            e_rej = cfg_load && !(cfg_prescale inside {6'd4, 6'd8, 6'd16, 6'd32});
            if (cfg_load && !e_rej) begin
                m_pend = 1'b1; m_pen = cfg_par_en; m_ptyp = cfg_par_typ; m_ppre = cfg_prescale;
            end
            if (!m_in_frame) begin
                if (lerr) inc = 1'b1;
                else if (acc && rx_p_data == 8'hA5) begin
                    m_in_frame = 1'b1; m_buf.delete(); m_silent = 0;
                end
            end else if (lerr) begin
                n_ferr = 1'b1; n_code = 2'b01;
            end else if (acc) begin
                m_silent = 0;
                m_buf.push_back(rx_p_data);
                if (m_buf.size() == 1 && m_buf[0] != 8'h01 && m_buf[0] != 8'h02) begin
                    n_ferr = 1'b1; n_code = 2'b10;
                end else begin
                    need = (m_buf[0] == 8'h01) ? 4 : 3;
                    if (m_buf.size() == 2) m_addr = rx_p_data;
                    if (m_buf.size() == 3 && need == 4) m_wdata = rx_p_data;
                    if (m_buf.size() == need) begin
                        x = 8'h00;
                        for (int i = 0; i < need - 1; i++) x = x ^ m_buf[i];
                        if (x == m_buf[need-1]) begin
                            n_wr = (need == 4); n_rd = (need == 3);
                        end else begin
                            n_ferr = 1'b1; n_code = 2'b11;
                        end
                        m_in_frame = 1'b0;
                    end
                end
            end else begin
                m_silent++;
                if (m_silent == T) begin
                    n_ferr = 1'b1; n_code = 2'b00;
                end
            end
            if (n_ferr) begin
                m_in_frame = 1'b0; inc = 1'b1; e_code = n_code;
            end
            if (err_cnt_clr) m_cnt = 0;
            else if (inc && m_cnt < 255) m_cnt++;
            e_wr = n_wr; e_rd = n_rd; e_ferr = n_ferr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit perr);
        rx_p_data = b; rx_data_valid = 1'b1; rx_par_err = perr; RX_IN = 1'b0;
        tick(1);
        rx_data_valid = 1'b0; rx_par_err = 1'b0; RX_IN = 1'b1;
        tick(3);
    endtask

    // Bytes are taken MSB first from f; err_idx marks the byte that carries a parity error.
    task automatic send_frame(input logic [39:0] f, input int n, input int err_idx);
        for (int i = 0; i < n; i++) send_byte(f[39-8*i -: 8], (i == err_idx));
    endtask

    task automatic load_cfg(input logic en, input logic typ, input logic [5:0] pre);
        cfg_par_en = en; cfg_par_typ = typ; cfg_prescale = pre; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        RST = 1'b1;
        tick(2);
        check("rst_prescale", rx_prescale, 8);
        check("rst_par_en", rx_par_en, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_code", err_code, 0);
        check("rst_addr", reg_addr, 0);

        send_frame({8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D}, 5, -1);
        tick(2);
        check("wr_count", wr_seen, 1);
        check("wr_addr", reg_addr, 8'h10);
        check("wr_data", reg_wdata, 8'h3C);
        check("wr_no_err", ferr_seen, 0);

        send_frame({8'hA5, 8'h02, 8'h20, 8'h22, 8'h00}, 4, -1);
        tick(2);
        check("rd_count", rd_seen, 1);
        check("rd_no_wr", wr_seen, 1);
        check("rd_addr", reg_addr, 8'h20);

        send_frame({8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2E}, 5, -1);
        tick(2);
        check("chk_code", last_code, 2'b11);
        check("chk_cnt", err_cnt, 1);
        check("chk_no_wr", wr_seen, 1);
        send_frame({8'hA5, 8'h07, 24'h0}, 2, -1);
        tick(2);
        check("cmd_code", last_code, 2'b10);
        check("cmd_cnt", err_cnt, 2);
        check("model_cnt", m_cnt, 2);

        load_cfg(1'b1, 1'b0, 6'd8);
        tick(110);
        check("par_en_applied", rx_par_en, 1);
        send_frame({8'hA5, 8'h02, 8'h20, 8'h22, 8'h00}, 4, 2);
        tick(2);
        check("par_code", last_code, 2'b01);
        check("par_cnt", err_cnt, 3);
        send_frame({8'hA5, 8'h02, 8'h20, 8'h22, 8'h00}, 4, -1);
        tick(2);
        check("par_then_rd", rd_seen, 2);

        send_frame({8'hA5, 8'h01, 24'h0}, 2, -1);
        tick(T + 10);
        check("to_code", last_code, 2'b00);
        check("to_cnt", err_cnt, 4);

        rx_stp_err = 1'b1;
        tick(1);
        rx_stp_err = 1'b0;
        tick(2);
        check("idle_lerr_cnt", err_cnt, 5);
        check("idle_lerr_noferr", ferr_seen, 4);

        rx_par_err = 1'b1;
        tick(260);
        rx_par_err = 1'b0;
        tick(2);
        check("sat_cnt", err_cnt, 8'hFF);
        rx_stp_err = 1'b1; err_cnt_clr = 1'b1;
        tick(1);
        rx_stp_err = 1'b0; err_cnt_clr = 1'b0;
        tick(2);
        check("clr_cnt", err_cnt, 0);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        load_cfg(1'b1, 1'b1, 6'd16);
        send_byte(8'h10, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h2D, 1'b0);
        tick(87);
        check("cfg_hold_pre", rx_prescale, 8);
        check("cfg_hold_typ", rx_par_typ, 0);
        tick(20);
        check("cfg_new_pre", rx_prescale, 16);
        check("cfg_new_typ", rx_par_typ, 1);
        check("cfg_frame_wr", wr_seen, 2);

        load_cfg(1'b0, 1'b0, 6'd12);
        tick(2);
        check("rej_seen", rej_seen, 1);
        tick(500);
        check("rej_pre_kept", rx_prescale, 16);

        rx_stp_err = 1'b1;
        tick(1);
        rx_stp_err = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        load_cfg(1'b0, 1'b0, 6'd4);
        RST = 1'b0;
        tick(2);
        check("mrst_cnt", err_cnt, 0);
        check("mrst_pre", rx_prescale, 8);
        check("mrst_addr", reg_addr, 0);
        RST = 1'b1;
        send_byte(8'h3C, 1'b0);
        send_byte(8'h2D, 1'b0);
        tick(500);
        check("mrst_no_wr", wr_seen, 2);
        check("mrst_no_apply", rx_prescale, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
